// File: rtl/pipeline_stall_ctrl_if.sv
// Handshake bundle between the pipeline hazard sources and the stall/flush sequencer.
// The master drives the hazard inputs; the slave (sequencer) drives the stage controls.
interface pipeline_stall_ctrl_if #(
  parameter int unsigned RA_W  = 5,
  parameter int unsigned CNT_W = 16
);
  logic [RA_W-1:0]  id_rs;
  logic [RA_W-1:0]  id_rt;
  logic             id_uses_rt;
  logic             id_md_op;
  logic [RA_W-1:0]  ex_rt;
  logic             ex_mem_read;
  logic             ex_branch_taken;
  logic             pc_write;
  logic             if_id_write;
  logic             if_id_flush;
  logic             id_ex_write;
  logic             id_ex_bubble;
  logic             ex_mem_bubble;
  logic             md_busy;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;

  modport master (
    output id_rs, id_rt, id_uses_rt, id_md_op, ex_rt, ex_mem_read, ex_branch_taken,
    input  pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble,
           md_busy, stall_cycles, flush_count
  );

  modport slave (
    input  id_rs, id_rt, id_uses_rt, id_md_op, ex_rt, ex_mem_read, ex_branch_taken,
    output pc_write, if_id_write, if_id_flush, id_ex_write, id_ex_bubble, ex_mem_bubble,
           md_busy, stall_cycles, flush_count
  );
endinterface

// File: rtl/pipeline_stall_ctrl.sv
// Stall/flush sequencer for the 5-stage pipeline: merges branch flushes, load-use stalls
// and mul/div occupancy by fixed priority, with saturating stall/flush counters.
module pipeline_stall_ctrl #(
  parameter int unsigned MD_LATENCY = 8,
  parameter int unsigned CNT_W      = 16,
  parameter int unsigned RA_W       = 5
) (
  input logic                   clk,
  input logic                   rst,
  pipeline_stall_ctrl_if.slave  bus
);
  localparam int unsigned MdW = $clog2(MD_LATENCY) + 1;

  typedef enum logic {StRun, StMdWait} state_e;

  state_e           r_state;
  logic [MdW-1:0]   r_md_cnt;
  logic [CNT_W-1:0] r_stall_cnt;
  logic [CNT_W-1:0] r_flush_cnt;

  logic w_lu;
  logic w_md_issue;
  logic w_pc_write;
  logic w_if_id_write;
  logic w_if_id_flush;
  logic w_id_ex_write;
  logic w_id_ex_bubble;
  logic w_ex_mem_bubble;
  logic w_md_busy;

  always_comb begin
    w_lu = bus.ex_mem_read && (bus.ex_rt != RA_W'(0)) &&
           ((bus.ex_rt == bus.id_rs) || (bus.id_uses_rt && (bus.ex_rt == bus.id_rt)));
    w_md_issue      = 1'b0;
    w_pc_write      = 1'b1;
    w_if_id_write   = 1'b1;
    w_if_id_flush   = 1'b0;
    w_id_ex_write   = 1'b1;
    w_id_ex_bubble  = 1'b0;
    w_ex_mem_bubble = 1'b0;
    w_md_busy       = 1'b0;
    case (r_state)
      StRun: begin
        if (bus.ex_branch_taken) begin
          // The ID instruction is squashed, so its hazards are irrelevant.
          w_if_id_flush  = 1'b1;
          w_id_ex_bubble = 1'b1;
        end else if (w_lu) begin
          w_pc_write     = 1'b0;
          w_if_id_write  = 1'b0;
          w_id_ex_bubble = 1'b1;
        end else if (bus.id_md_op) begin
          w_md_issue = 1'b1;
        end
      end
      StMdWait: begin
        w_pc_write      = 1'b0;
        w_if_id_write   = 1'b0;
        w_id_ex_write   = 1'b0;
        w_ex_mem_bubble = 1'b1;
        w_md_busy       = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= StRun;
      r_md_cnt    <= '0;
      r_stall_cnt <= '0;
      r_flush_cnt <= '0;
    end else begin
      case (r_state)
        StRun: begin
          if (w_md_issue) begin
            r_state  <= StMdWait;
            r_md_cnt <= MdW'(MD_LATENCY - 1);
          end
        end
        StMdWait: begin
          if (r_md_cnt == '0) r_state <= StRun;
          else                r_md_cnt <= r_md_cnt - 1'b1;
        end
        default: r_state <= StRun;
      endcase
      if (!w_pc_write && (r_stall_cnt != '1)) r_stall_cnt <= r_stall_cnt + 1'b1;
      if (w_if_id_flush && (r_flush_cnt != '1)) r_flush_cnt <= r_flush_cnt + 1'b1;
    end
  end

  assign bus.pc_write      = w_pc_write;
  assign bus.if_id_write   = w_if_id_write;
  assign bus.if_id_flush   = w_if_id_flush;
  assign bus.id_ex_write   = w_id_ex_write;
  assign bus.id_ex_bubble  = w_id_ex_bubble;
  assign bus.ex_mem_bubble = w_ex_mem_bubble;
  assign bus.md_busy       = w_md_busy;
  assign bus.stall_cycles  = r_stall_cnt;
  assign bus.flush_count   = r_flush_cnt;
endmodule
